// File: rtl/lieat_exu_disp_rcv.sv
// lieat_exu_disp_rcv: dispatch receive FIFO between the ID-stage dispatch port and one execution unit
module lieat_exu_disp_rcv #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_req,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [DW-1:0]    disp_payload,
    output logic             exe_valid,
    input  logic             exe_ready,
    output logic [DW-1:0]    exe_payload,
    output logic [PTR_W:0]   occupancy,
    output logic             empty,
    output logic             full
);
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] ptr_diff;
    logic             push, pop;

    // Status and handshakes; disp_ready comes from registered count only, so exe_ready never reaches it
    always_comb begin
        empty       = count_q == '0;
        full        = count_q == (PTR_W+1)'(DEPTH);
        occupancy   = count_q;
        disp_ready  = ~full;
        exe_valid   = ~empty & ~flush_req;
        exe_payload = mem_q[rd_ptr_q];
        push        = disp_valid & disp_ready;
        pop         = exe_valid & exe_ready;
        ptr_diff    = wr_ptr_q - rd_ptr_q;
    end

    // Next-state: flush discards everything including a same-cycle push
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = disp_payload;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is left unreset; contents are only observed behind exe_valid
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    a_count_ptr: assert property (@(posedge clock) disable iff (!reset)
        full || count_q == {1'b0, ptr_diff});
    a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset)
        !(pop && empty));
    a_occ_bound: assert property (@(posedge clock) disable iff (!reset)
        count_q <= (PTR_W+1)'(DEPTH));
endmodule

// File: tb/tb_lieat_exu_disp_rcv.sv
// tb_lieat_exu_disp_rcv: directed stimulus with a queue scoreboard and a decoupled negedge monitor
module tb_lieat_exu_disp_rcv;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush_req = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [63:0] disp_payload = '0;
    logic        exe_valid;
    logic        exe_ready = 1'b0;
    logic [63:0] exe_payload;
    logic [2:0]  occupancy;
    logic        empty;
    logic        full;

    int checks = 0;
    int errors = 0;
    int popped = 0;
    bit started = 1'b0;
    logic [63:0] sb[$];

    lieat_exu_disp_rcv #(.DW(64), .DEPTH(4), .PTR_W(2)) dut (
        .clock(clock), .reset(reset), .flush_req(flush_req),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_payload(exe_payload),
        .occupancy(occupancy), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference queue: expected payloads are pushed as stimulus is accepted at each edge
    always @(posedge clock) begin
        if (!reset) begin
            sb.delete();
            started <= 1'b1;
        end else if (flush_req) begin
            sb.delete();
        end else if (disp_valid && sb.size() < 4) begin
            if (exe_ready && sb.size() > 0)
                void'(sb.pop_front());
            sb.push_back(disp_payload);
        end else if (exe_ready && sb.size() > 0) begin
            void'(sb.pop_front());
        end
    end

    // Monitor: samples mid-cycle and compares status and head payload with the reference queue
    always @(negedge clock) begin
        if (started) begin
            chk("exe_valid", 64'(exe_valid), 64'(sb.size() > 0 && !flush_req));
            chk("disp_ready", 64'(disp_ready), 64'(sb.size() < 4));
            chk("occupancy", 64'(occupancy), 64'(sb.size()));
            chk("empty", 64'(empty), 64'(sb.size() == 0));
            chk("full", 64'(full), 64'(sb.size() == 4));
            if (exe_valid && sb.size() > 0)
                chk("exe_payload", exe_payload, sb[0]);
            if (exe_valid && exe_ready)
                popped++;
        end
    end

    task automatic step(input logic v, input logic [63:0] p, input logic r, input logic f);
        disp_valid   = v;
        disp_payload = p;
        exe_ready    = r;
        flush_req    = f;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held two cycles
        repeat (2) step(0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0);
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_ready", 64'(disp_ready), 64'd1);
        // Fill then drain
        for (int i = 0; i < 4; i++) step(1, 64'hA0 + 64'(i), 0, 0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_occ", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Streaming 1..20
        for (int i = 1; i <= 20; i++) step(1, 64'(i), 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Wrap: three rounds of push 3 / pop 3
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) step(1, 64'h100 + 64'(k * 16 + i), 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        end
        step(0, 0, 0, 0);
        // Flush with three entries held and a push attempted in the flush cycle
        for (int i = 0; i < 3; i++) step(1, 64'hB0 + 64'(i), 0, 0);
        step(1, 64'hFF, 1, 1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        step(0, 0, 1, 0);
        // Full with simultaneous pop: push is refused, then accepted next cycle
        for (int i = 0; i < 4; i++) step(1, 64'hC0 + 64'(i), 0, 0);
        step(1, 64'hC4, 1, 0);
        chk("fullpop_occ", 64'(occupancy), 64'd3);
        step(1, 64'hC4, 0, 0);
        chk("fullpop_refill", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("final_empty", 64'(empty), 64'd1);
        chk("total_popped", 64'(popped), 64'd38);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
